// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding imem
// request/wait handshake and buffers fetched words in a prefetch FIFO
// feeding decode. Optional feature macro: IFU_MISALIGN_CHECK_EN (sticky
// misaligned-redirect flag; when undefined redirect_pc[1:0] is forced to 0).
module instruction_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_wait,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            fd_valid,
    input  logic            fd_ready,
    output logic [XLEN-1:0] fd_instruction,
    output logic [XLEN-1:0] fd_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic            fetch_misaligned
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   addr_d;
    logic [XLEN-1:0]   target_pc;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [XLEN-1:0]   fifo_instr [DEPTH];
    logic [XLEN-1:0]   fifo_pc    [DEPTH];
    logic              complete, push, pop, can_issue, issue, blocked;

    assign fd_valid       = (count_q != '0);
    assign fd_instruction = fifo_instr[rd_ptr];
    assign fd_pc          = fifo_pc[rd_ptr];

    // Handshake bookkeeping: completion, push/pop, post-cycle occupancy, space
    always_comb begin
        complete  = imem_req && !imem_wait;
        pop       = fd_valid && fd_ready;
        push      = (state_q == REQ) && complete && !redirect_valid;
        count_d   = redirect_valid ? '0 : (count_q + CW'(push) - CW'(pop));
`ifdef IFU_MISALIGN_CHECK_EN
        blocked   = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fetch_misaligned;
        target_pc = redirect_valid ? redirect_pc : pc_q;
`else
        blocked   = 1'b0;
        target_pc = redirect_valid ? (redirect_pc & ~XLEN'(3)) : pc_q;
`endif
        can_issue = (count_d < CW'(DEPTH)) && !blocked;
    end

    // Next-state: a completion or an idle slot may (re)issue; redirect mid-wait drops
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (can_issue) state_d = REQ;
            REQ: begin
                if (complete)            state_d = can_issue ? REQ : IDLE;
                else if (redirect_valid) state_d = DROP;
            end
            DROP: if (complete) state_d = can_issue ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Issue decode: new request latches target address and advances the PC
    always_comb begin
        issue  = ((state_q == IDLE) || complete) && (state_d == REQ);
        addr_d = issue ? target_pc : imem_addr;
        pc_d   = issue ? (target_pc + XLEN'(4)) : target_pc;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // PC, request outputs and misalignment flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            imem_addr <= RESET_PC;
            imem_req  <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
            fetch_misaligned <= 1'b0;
`endif
        end else begin
            pc_q      <= pc_d;
            imem_addr <= addr_d;
            imem_req  <= (state_d != IDLE);
`ifdef IFU_MISALIGN_CHECK_EN
            if (redirect_valid) fetch_misaligned <= (redirect_pc[1:0] != 2'b00);
`endif
        end
    end

    // Prefetch FIFO; redirect flushes and overrides same-cycle push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            count_q <= count_d;
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_instr[wr_ptr] <= imem_rdata;
                    fifo_pc[wr_ptr]    <= imem_addr;
                    wr_ptr             <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Parametrised instruction fetch stage for the pipelined RV32 core. It owns the program counter and drives the instruction-memory request/wait handshake with at most one request outstanding. Fetched words go into a DEPTH-entry prefetch FIFO that feeds decode through a valid/ready interface. Branch/jump redirects flush the FIFO and discard any in-flight response, replacing the ad-hoc fetch bookkeeping and pc-zero bubble encoding inside the control section.

## Interface
Parameters:
- XLEN, 32: address and instruction width.
- DEPTH, 4: prefetch FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports (clock, then reset, then the rest):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_req  output  1  request asserted; address held stable until completion.
- imem_addr  output  XLEN  fetch address of the current request.
- imem_wait  input  1  memory busy; a request completes in any cycle with imem_req=1 and imem_wait=0.
- imem_rdata  input  XLEN  instruction word; valid only in the completion cycle.
- fd_valid  output  1  FIFO head is valid.
- fd_ready  input  1  decode accepts the head this cycle.
- fd_instruction  output  XLEN  head instruction.
- fd_pc  output  XLEN  address of the head instruction.
- redirect_valid  input  1  single-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  input  XLEN  new fetch address.
- fetch_misaligned  output  1  sticky misaligned-redirect flag; present only with IFU_MISALIGN_CHECK_EN.

## Operation
- The FSM has three states. IDLE drives imem_req=0. REQ drives imem_req=1 and keeps the response. DROP drives imem_req=1 and discards the response.
- Space check: a request may issue when count_next + 1 <= DEPTH. count_next is the occupancy after this cycle's pop/push.
- IDLE -> REQ on space. At issue, imem_addr <= pc and pc <= pc + 4 (modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0).
- REQ, completion: push {imem_addr, imem_rdata}. If space remains, reissue back-to-back in the same edge; otherwise go to IDLE.
- REQ, no completion: stay in REQ with imem_addr unchanged.
- Redirect in REQ without completion: pc <= redirect_pc, flush the FIFO, go to DROP.
- DROP, completion: discard the data; go to REQ with imem_addr <= pc and pc <= pc + 4.
- Redirect while already in DROP: update pc and stay in DROP.
- Redirect in IDLE, or in REQ in a completion cycle: flush, discard the completing word, pc <= redirect_pc. The next state is REQ if idle-issue is possible, else IDLE.
- A redirect always wins over a same-cycle push and a same-cycle pop.
- Pop happens when fd_valid && fd_ready. The FIFO is never pushed when full, because the space check accounts for the in-flight request.
- Reset mid-request drops imem_req immediately (asynchronous) and abandons the transaction.

## Timing
- Reset values:
  - Outputs: imem_req=0, imem_addr=RESET_PC, fd_valid=0, fd_instruction=0, fd_pc=0, fetch_misaligned=0.
  - Internal: pc=RESET_PC, count=0, state=IDLE.
- First edge after reset release: IDLE -> REQ. With a zero-wait memory, fd_valid=1 with fd_pc=RESET_PC two cycles after release.
- Steady state with zero-wait memory and fd_ready=1: one instruction per cycle.
- Fetch-to-decode latency: 1 cycle from the completion edge; there is no bypass.
- After a redirect: fd_valid=0 on the next cycle. The first redirected instruction appears no earlier than 2 cycles after the pulse, plus any outstanding wait cycles in DROP.
- fd_instruction and fd_pc hold stable while fd_valid && !fd_ready.

## Configuration
- IFU_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 flushes the FIFO, sets fetch_misaligned, and blocks further issue. Any in-flight request still completes and is discarded.
  - The next aligned redirect clears the flag and resumes fetching.
- IFU_MISALIGN_CHECK_EN undefined:
  - The fetch_misaligned port is absent.
  - redirect_pc[1:0] is forced to 0.

## Test plan
- Reset release, zero-wait memory, fd_ready=1: fd_pc sequence 0x0, 0x4, 0x8, ... one per cycle; imem_req stays high continuously.
- DEPTH=4, fd_ready=0: exactly 4 completions, then imem_req=0. One fd_ready pulse yields exactly one new request.
- imem_wait high for 3 cycles with a redirect to 0x100 in wait cycle 2: imem_addr stays at the old address until completion. That word is discarded, and the next delivered fd_pc=0x100.
- Redirect to 0x40 in the same cycle as a completion and a pop: the FIFO is empty next cycle, and the first fd_pc=0x40.
- pc=32'hFFFF_FFFC: the next fetch address is 0x0.
- With IFU_MISALIGN_CHECK_EN, redirect to 0x102: fetch_misaligned=1 and no new issue. A subsequent redirect to 0x104 clears the flag, and fd_pc=0x104 is delivered.
